// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard entry,
// forwarding select encoding and the hard-wired zero register index.
package pipe_ctrl_pkg;

  // Scoreboard destination field is sized for the widest supported register index.
  localparam int SB_DEST_W = 8;

  localparam logic [SB_DEST_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                 valid;
    logic                 reg_wr;
    logic                 rd_mem;
    logic [SB_DEST_W-1:0] dest;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/hazard_match.sv
// Producer/consumer comparator: flags a read of a register that an older
// in-flight instruction is going to write. x0 never matches.
module hazard_match
  import pipe_ctrl_pkg::*;
(
  input  sb_entry_t            producer,
  input  logic [SB_DEST_W-1:0] rs,
  input  logic                 rs_used,
  input  logic                 consumer_valid,
  output logic                 match
);

  assign match = consumer_valid & rs_used &
                 producer.valid & producer.reg_wr &
                 (producer.dest != ZERO_REG) & (producer.dest == rs);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Central pipeline controller for the 5-stage core: register enables and
// flushes, load-use bubbles, registered EX forwarding selects, data-memory
// freeze and saturating performance counters.
module hazard_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_IDX_W = 5,
  parameter int LU_STALL  = 1,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [1:0]           id_rs_used,
  input  logic                 id_reg_wr,
  input  logic                 id_rd_mem,
  input  logic [REG_IDX_W-1:0] id_dest,
  input  logic                 ex_take_branch,
  input  logic                 dmem_busy,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 id_ex_en,
  output logic                 ex_mem_en,
  output logic                 mem_wb_en,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic [1:0]           fwd_sel_a,
  output logic [1:0]           fwd_sel_b,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt,
  output logic [CNT_W-1:0]     freeze_cnt
);

  // Shadow occupants of EX, MEM and WB
  sb_entry_t sb_p0, sb_p1, sb_p2;
  logic [1:0] lu_cnt;

  logic [SB_DEST_W-1:0] rs1_w, rs2_w;
  sb_entry_t id_entry;
  logic m_ex_a, m_ex_b, m_mem_a, m_mem_b;
  logic freeze, branch, lu_detect, stall;
  fwd_sel_e fwd_a_nxt, fwd_b_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (&c) ? c : c + 1'b1;
  endfunction

  // The younger (EX) producer wins; a WB producer is covered by regfile write-through.
  function automatic fwd_sel_e fwd_pick(input logic ex_m, input logic mem_m);
    fwd_pick = FWD_RF;
    if (ex_m)       fwd_pick = FWD_EXMEM;
    else if (mem_m) fwd_pick = FWD_MEMWB;
  endfunction

  assign rs1_w    = SB_DEST_W'(id_rs1);
  assign rs2_w    = SB_DEST_W'(id_rs2);
  assign id_entry = '{valid: id_valid, reg_wr: id_reg_wr, rd_mem: id_rd_mem,
                      dest: SB_DEST_W'(id_dest)};

  hazard_match u_ex_a  (.producer(sb_p0), .rs(rs1_w), .rs_used(id_rs_used[0]),
                        .consumer_valid(id_valid), .match(m_ex_a));
  hazard_match u_ex_b  (.producer(sb_p0), .rs(rs2_w), .rs_used(id_rs_used[1]),
                        .consumer_valid(id_valid), .match(m_ex_b));
  hazard_match u_mem_a (.producer(sb_p1), .rs(rs1_w), .rs_used(id_rs_used[0]),
                        .consumer_valid(id_valid), .match(m_mem_a));
  hazard_match u_mem_b (.producer(sb_p1), .rs(rs2_w), .rs_used(id_rs_used[1]),
                        .consumer_valid(id_valid), .match(m_mem_b));

  // The WB entry is kept for a complete picture of the pipe; write-through means no select needs it.
  logic wb_unused;
  assign wb_unused = ^sb_p2;

  assign freeze    = dmem_busy;
  assign branch    = ex_take_branch & ~freeze;
  // The detection cycle is itself the first bubble, so the countdown holds the remaining ones.
  assign lu_detect = (lu_cnt == 2'd0) & sb_p0.rd_mem & (m_ex_a | m_ex_b);
  assign stall     = lu_detect | (lu_cnt != 2'd0);
  assign fwd_a_nxt = fwd_pick(m_ex_a, m_ex_b & 1'b0 | m_ex_a & 1'b0 | m_ex_a ? 1'b0 : m_mem_a);
  assign fwd_b_nxt = fwd_pick(m_ex_b, m_mem_b);

  // Enables and flushes by priority: freeze, branch, load-use bubble, normal flow
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (freeze) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (branch) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (stall) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // Scoreboard shifts with the pipeline; bubbles and flushes enter as empty entries
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_p0.valid <= 1'b0;
      sb_p1.valid <= 1'b0;
      sb_p2.valid <= 1'b0;
    end else if (!freeze) begin
      sb_p2 <= sb_p1;
      sb_p1 <= sb_p0;
      sb_p0 <= id_ex_flush ? SB_EMPTY : id_entry;
    end
  end

  // Load-use countdown: cleared by a branch, held by a freeze
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt <= 2'd0;
    end else if (!freeze) begin
      if (branch)                lu_cnt <= 2'd0;
      else if (lu_cnt != 2'd0)   lu_cnt <= lu_cnt - 2'd1;
      else if (lu_detect)        lu_cnt <= 2'(LU_STALL - 1);
    end
  end

  // Forwarding selects follow the instruction into EX; a bubble never forwards
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_sel_a <= FWD_RF;
      fwd_sel_b <= FWD_RF;
    end else if (id_ex_en) begin
      fwd_sel_a <= id_ex_flush ? FWD_RF : fwd_a_nxt;
      fwd_sel_b <= id_ex_flush ? FWD_RF : fwd_b_nxt;
    end
  end

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else if (freeze) begin
      freeze_cnt <= sat_inc(freeze_cnt);
    end else if (branch) begin
      flush_cnt  <= sat_inc(flush_cnt);
    end else if (stall) begin
      stall_cnt  <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two instances (LU_STALL=1 / 32-bit counters and
// LU_STALL=3 / 3-bit counters) share stimulus and are compared every cycle
// against an instruction-level model of the EX/MEM/WB occupants.
module tb_hazard_ctrl_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_valid, id_reg_wr, id_rd_mem, ex_take_branch, dmem_busy;
  logic [4:0] id_rs1, id_rs2, id_dest;
  logic [1:0] id_rs_used;

  logic       o_pc[2], o_ifid[2], o_idex[2], o_exmem[2], o_memwb[2], o_iff[2], o_idf[2];
  logic [1:0] o_fa[2], o_fb[2];
  logic [31:0] s0, f0, z0;
  logic [2:0]  s1, f1, z1;

  hazard_ctrl_unit #(.REG_IDX_W(5), .LU_STALL(1), .CNT_W(32)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs_used(id_rs_used), .id_reg_wr(id_reg_wr), .id_rd_mem(id_rd_mem),
    .id_dest(id_dest), .ex_take_branch(ex_take_branch), .dmem_busy(dmem_busy),
    .pc_en(o_pc[0]), .if_id_en(o_ifid[0]), .id_ex_en(o_idex[0]),
    .ex_mem_en(o_exmem[0]), .mem_wb_en(o_memwb[0]), .if_id_flush(o_iff[0]),
    .id_ex_flush(o_idf[0]), .fwd_sel_a(o_fa[0]), .fwd_sel_b(o_fb[0]),
    .stall_cnt(s0), .flush_cnt(f0), .freeze_cnt(z0));

  hazard_ctrl_unit #(.REG_IDX_W(5), .LU_STALL(3), .CNT_W(3)) u3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs_used(id_rs_used), .id_reg_wr(id_reg_wr), .id_rd_mem(id_rd_mem),
    .id_dest(id_dest), .ex_take_branch(ex_take_branch), .dmem_busy(dmem_busy),
    .pc_en(o_pc[1]), .if_id_en(o_ifid[1]), .id_ex_en(o_idex[1]),
    .ex_mem_en(o_exmem[1]), .mem_wb_en(o_memwb[1]), .if_id_flush(o_iff[1]),
    .id_ex_flush(o_idf[1]), .fwd_sel_a(o_fa[1]), .fwd_sel_b(o_fb[1]),
    .stall_cnt(s1), .flush_cnt(f1), .freeze_cnt(z1));

  int checks = 0;
  int failures = 0;

  // Reference model: the instructions occupying EX(0), MEM(1), WB(2).
  typedef struct {bit v; bit wr; bit ld; int rd;} slot_t;
  slot_t  mp[2][3];
  int     mbl[2];              // bubbles still owed
  int     mfa[2], mfb[2];      // select seen by the instruction now in EX
  longint msc[2], mfc[2], mzc[2];
  int     lu_len[2] = '{1, 3};
  longint cmax[2]   = '{64'hFFFF_FFFF, 64'd7};

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL u%0d %s observed=%0h expected=%0h", k, tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt(input int k, input int w);
    case (w)
      0:       return (k == 0) ? s0 : 32'(s1);
      1:       return (k == 0) ? f0 : 32'(f1);
      default: return (k == 0) ? z0 : 32'(z1);
    endcase
  endfunction

  function automatic bit dep(input slot_t p, input int rs, input bit used);
    return id_valid && used && p.v && p.wr && p.rd != 0 && p.rd == rs;
  endfunction

  function automatic int src(input int k, input int rs, input bit used);
    if (dep(mp[k][0], rs, used)) return 1;
    if (dep(mp[k][1], rs, used)) return 2;
    return 0;
  endfunction

  task automatic cycle();
    bit br;
    bit lu[2];
    bit stl[2];
    slot_t nx;
    @(negedge clk);
    br = ex_take_branch && !dmem_busy;
    for (int k = 0; k < 2; k++) begin
      lu[k]  = (mbl[k] == 0) && mp[k][0].ld &&
               (dep(mp[k][0], int'(id_rs1), id_rs_used[0]) || dep(mp[k][0], int'(id_rs2), id_rs_used[1]));
      stl[k] = !dmem_busy && !br && (mbl[k] > 0 || lu[k]);
      if (!rst) begin
        chk("pc_en",       k, 32'(o_pc[k]),    32'(!dmem_busy && !stl[k]));
        chk("if_id_en",    k, 32'(o_ifid[k]),  32'(!dmem_busy && !stl[k]));
        chk("id_ex_en",    k, 32'(o_idex[k]),  32'(!dmem_busy));
        chk("ex_mem_en",   k, 32'(o_exmem[k]), 32'(!dmem_busy));
        chk("mem_wb_en",   k, 32'(o_memwb[k]), 32'(!dmem_busy));
        chk("if_id_flush", k, 32'(o_iff[k]),   32'(br));
        chk("id_ex_flush", k, 32'(o_idf[k]),   32'(br || stl[k]));
        chk("fwd_sel_a",   k, 32'(o_fa[k]),    32'(mfa[k]));
        chk("fwd_sel_b",   k, 32'(o_fb[k]),    32'(mfb[k]));
        chk("stall_cnt",   k, cnt(k, 0),       32'(msc[k]));
        chk("flush_cnt",   k, cnt(k, 1),       32'(mfc[k]));
        chk("freeze_cnt",  k, cnt(k, 2),       32'(mzc[k]));
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int j = 0; j < 3; j++) mp[k][j] = '{v: 1'b0, wr: 1'b0, ld: 1'b0, rd: 0};
        mbl[k] = 0; mfa[k] = 0; mfb[k] = 0;
        msc[k] = 0; mfc[k] = 0; mzc[k] = 0;
      end else if (dmem_busy) begin
        if (mzc[k] < cmax[k]) mzc[k]++;
      end else begin
        if (br || stl[k]) begin
          nx = '{v: 1'b0, wr: 1'b0, ld: 1'b0, rd: 0};
          mfa[k] = 0; mfb[k] = 0;
        end else begin
          nx.v = id_valid; nx.wr = id_reg_wr; nx.ld = id_rd_mem; nx.rd = int'(id_dest);
          mfa[k] = src(k, int'(id_rs1), id_rs_used[0]);
          mfb[k] = src(k, int'(id_rs2), id_rs_used[1]);
        end
        mp[k][2] = mp[k][1];
        mp[k][1] = mp[k][0];
        mp[k][0] = nx;
        if (br) begin
          if (mfc[k] < cmax[k]) mfc[k]++;
          mbl[k] = 0;
        end else if (stl[k]) begin
          if (msc[k] < cmax[k]) msc[k]++;
          if (lu[k]) mbl[k] = lu_len[k];
          mbl[k]--;
        end
      end
    end
    #1;
  endtask

  task automatic nop();
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs_used = '0;
    id_reg_wr = 1'b0; id_rd_mem = 1'b0; id_dest = '0;
  endtask

  task automatic ins(input int rd, input int r1, input int r2, input logic [1:0] used,
                     input bit wr, input bit ld);
    id_valid = 1'b1; id_dest = 5'(rd); id_rs1 = 5'(r1); id_rs2 = 5'(r2);
    id_rs_used = used; id_reg_wr = wr; id_rd_mem = ld;
  endtask

  initial begin
    rst = 1'b1; ex_take_branch = 1'b0; dmem_busy = 1'b0; nop();
    cycle();
    rst = 1'b0;

    // Reset in the middle of a stall (u3 countdown at 1) while memory is busy
    ins(5, 0, 0, 2'b00, 1, 1); cycle();
    ins(6, 0, 5, 2'b10, 1, 0); cycle(); cycle();
    rst = 1'b1; dmem_busy = 1'b1; cycle();
    rst = 1'b0; dmem_busy = 1'b0; nop(); #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_pc_en",  k, 32'(o_pc[k]),   32'd1);
      chk("rst_id_ex_en", k, 32'(o_idex[k]), 32'd1);
      chk("rst_mem_wb_en", k, 32'(o_memwb[k]), 32'd1);
      chk("rst_flushes", k, 32'({o_iff[k], o_idf[k]}), 32'd0);
      chk("rst_fwd",    k, 32'({o_fa[k], o_fb[k]}), 32'd0);
      chk("rst_stall_cnt", k, cnt(k, 0), 32'd0);
      chk("rst_freeze_cnt", k, cnt(k, 2), 32'd0);
    end
    cycle();

    // add x5 ; sub x6,x5,x7 -> EX/MEM forward on operand a, no stall
    ins(5, 1, 2, 2'b11, 1, 0); cycle();
    ins(6, 5, 7, 2'b11, 1, 0); cycle();
    nop(); #1;
    for (int k = 0; k < 2; k++) begin
      chk("fwd_ex_a",     k, 32'(o_fa[k]), 32'd1);
      chk("fwd_ex_b",     k, 32'(o_fb[k]), 32'd0);
      chk("fwd_ex_nostall", k, 32'(o_pc[k]), 32'd1);
      chk("fwd_ex_stall_cnt", k, cnt(k, 0), 32'd0);
    end
    cycle();

    // lw x5 ; add x6,x0,x5 -> load-use bubbles
    ins(5, 0, 0, 2'b00, 1, 1); cycle();
    ins(6, 0, 5, 2'b11, 1, 0); #1;
    chk("lu_t0_pc_en", 0, 32'(o_pc[0]), 32'd0);
    chk("lu_t0_id_ex_flush", 0, 32'(o_idf[0]), 32'd1);
    chk("lu_t0_pc_en", 1, 32'(o_pc[1]), 32'd0);
    cycle();
    #1;
    chk("lu_t1_pc_en", 0, 32'(o_pc[0]), 32'd1);
    chk("lu_t1_id_ex_flush", 0, 32'(o_idf[0]), 32'd0);
    chk("lu_t1_pc_en", 1, 32'(o_pc[1]), 32'd0);
    cycle();
    #1;
    chk("lu_fwd_memwb", 0, 32'(o_fb[0]), 32'd2);
    chk("lu_stall_cnt", 0, cnt(0, 0), 32'd1);
    chk("lu_t2_pc_en", 1, 32'(o_pc[1]), 32'd0);
    cycle();
    #1;
    chk("lu_t3_pc_en", 1, 32'(o_pc[1]), 32'd1);
    chk("lu_stall_cnt", 1, cnt(1, 0), 32'd3);
    cycle();
    nop(); #1;
    chk("lu3_fwd_rf", 1, 32'(o_fb[1]), 32'd0);
    chk("lu_stall_cnt_final", 0, cnt(0, 0), 32'd1);
    cycle();

    // Taken branch while a load-use stall is pending
    ins(5, 0, 0, 2'b00, 1, 1); cycle();
    ins(6, 5, 0, 2'b01, 1, 0); cycle();
    ex_take_branch = 1'b1; #1;
    for (int k = 0; k < 2; k++) begin
      chk("br_if_id_flush", k, 32'(o_iff[k]), 32'd1);
      chk("br_id_ex_flush", k, 32'(o_idf[k]), 32'd1);
      chk("br_enables", k, 32'({o_pc[k], o_ifid[k], o_idex[k], o_exmem[k], o_memwb[k]}), 32'h1f);
    end
    cycle();
    ex_take_branch = 1'b0; nop(); #1;
    for (int k = 0; k < 2; k++) begin
      chk("br_countdown_cleared", k, 32'(o_pc[k]), 32'd1);
      chk("br_flush_cnt", k, cnt(k, 1), 32'd1);
      chk("br_no_fwd", k, 32'({o_fa[k], o_fb[k]}), 32'd0);
    end
    cycle();

    // Freeze for four cycles with a branch waiting in EX
    ex_take_branch = 1'b1; dmem_busy = 1'b1;
    repeat (4) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        chk("frz_enables", k, 32'({o_pc[k], o_ifid[k], o_idex[k], o_exmem[k], o_memwb[k]}), 32'd0);
        chk("frz_flushes", k, 32'({o_iff[k], o_idf[k]}), 32'd0);
      end
      cycle();
    end
    dmem_busy = 1'b0; #1;
    for (int k = 0; k < 2; k++) begin
      chk("frz_freeze_cnt", k, cnt(k, 2), 32'd4);
      chk("frz_late_flush", k, 32'(o_iff[k]), 32'd1);
    end
    cycle();
    ex_take_branch = 1'b0; #1;
    for (int k = 0; k < 2; k++) chk("frz_flush_cnt", k, cnt(k, 1), 32'd2);
    cycle();

    // Writing x0 and then reading it never forwards
    ins(0, 0, 0, 2'b00, 1, 0); cycle();
    ins(7, 0, 0, 2'b11, 1, 0); cycle();
    nop(); #1;
    for (int k = 0; k < 2; k++) chk("x0_no_fwd", k, 32'({o_fa[k], o_fb[k]}), 32'd0);
    cycle();

    // Five more frozen cycles: the 3-bit counter pins at all-ones
    dmem_busy = 1'b1; repeat (5) cycle();
    dmem_busy = 1'b0; #1;
    chk("sat_freeze_cnt", 1, cnt(1, 2), 32'd7);
    chk("sat_freeze_cnt", 0, cnt(0, 2), 32'd9);
    cycle();

    // Randomized traffic over a small register set so hazards are frequent
    repeat (800) begin
      rst            = ($urandom_range(0, 99) < 2);
      dmem_busy      = ($urandom_range(0, 99) < 20);
      ex_take_branch = ($urandom_range(0, 99) < 12);
      id_valid       = ($urandom_range(0, 99) < 80);
      id_rs1         = 5'($urandom_range(0, 3));
      id_rs2         = 5'($urandom_range(0, 3));
      id_dest        = 5'($urandom_range(0, 3));
      id_rs_used     = 2'($urandom_range(0, 3));
      id_reg_wr      = ($urandom_range(0, 99) < 75);
      id_rd_mem      = ($urandom_range(0, 99) < 35);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Centralised, parametrised pipeline controller for the 5-stage RV32 core. It replaces the hard-wired enables and the per-stage branch NOOP muxes. It keeps a shadow scoreboard of the EX/MEM/WB occupants and generates, per cycle:
- per-register enables and flushes;
- load-use stalls of configurable length;
- registered operand-forwarding selects for EX;
- a global freeze for multi-cycle data memory.

It also provides saturating performance counters.

Parameters:
- REG_IDX_W, 5, width of register index.
- LU_STALL, 1, bubbles inserted on load-use hazard (legal 1..3).
- CNT_W, 32, width of each perf counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- id_valid  in  1  instruction valid in ID.
- id_rs1, id_rs2  in  REG_IDX_W each  ID source indices.
- id_rs_used  in  2  bit0 = rs1 read, bit1 = rs2 read.
- id_reg_wr  in  1  ID instruction writes rd.
- id_rd_mem  in  1  ID instruction is a load.
- id_dest  in  REG_IDX_W  ID destination index.
- ex_take_branch  in  1  taken branch/jump resolved in EX this cycle.
- dmem_busy  in  1  data memory not ready; whole pipeline must hold.
- pc_en  out  1  PC update enable.
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register enables.
- if_id_flush, id_ex_flush  out  1 each  load NOOP/invalid into register when enabled.
- fwd_sel_a, fwd_sel_b  out  2 each  EX operand source: 0 = regfile value, 1 = ex_mem_alu_result, 2 = wb_reg_wr_data_out; 3 is reserved.
- stall_cnt, flush_cnt, freeze_cnt  out  CNT_W each  perf counters.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - rst dominates all other inputs.
  - Scoreboard entries are invalid, the load-use countdown is 0, fwd_sel_* = 0, and all counters = 0.
  - Enables remain combinational from state; after reset all enables = 1 and all flushes = 0.
- Scoreboard: three entries, EX/MEM/WB, each holding {valid, reg_wr, rd_mem, dest}.
  - It advances exactly when the matching pipeline registers advance.
  - The EX entry loads ID info, or an invalid entry when id_ex_flush or a bubble is inserted.
- Hazard match: producer.valid & producer.reg_wr & dest != 0 & dest == rs & rs_used. Register x0 never matches.
- Forwarding: fwd_sel_* is computed in ID against the EX and MEM entries and registered on id_ex_en.
  - EX entry match -> 1; else MEM entry match -> 2; else 0. The younger producer wins.
  - The value is held while id_ex_en = 0.
  - The regfile is write-through for a WB-stage producer, so that case selects 0.
- Load-use: an EX entry with rd_mem that matches an ID source loads the countdown with LU_STALL.
  - While the countdown is nonzero: pc_en = if_id_en = 0, id_ex_en = 1, id_ex_flush = 1 (bubble), the countdown decrements, and stall_cnt increments.
  - After the final bubble, forwarding resolves normally: select 2 for LU_STALL = 1, select 0 for larger values.
- Branch: ex_take_branch (not frozen) asserts if_id_flush = id_ex_flush = 1 with all enables = 1.
  - It clears the countdown (the stalled instruction is squashed) and increments flush_cnt.
- Freeze: dmem_busy drives all enables (PC included) to 0 and all flushes to 0.
  - The scoreboard, countdown and fwd_sel hold; freeze_cnt increments.
  - A branch asserted during freeze is acted on in the first unfrozen cycle, because the EX register holds.
- Priority: rst > dmem_busy > ex_take_branch > load-use > normal.
- Counters saturate at all-ones; they do not wrap.
- An invalid ID instruction (id_valid = 0) never raises a hazard.
- Bubbles and flushed entries never cause forwarding.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - typedef sb_entry_t {valid, reg_wr, rd_mem, dest};
  - enum fwd_sel_e {FWD_RF = 0, FWD_EXMEM = 1, FWD_MEMWB = 2};
  - constant ZERO_REG.
- One sub-module, hazard_match: combinational producer/consumer comparator, instantiated once per (entry, source) pair.
- Counters and the countdown live in the top module.

Test Plan:
- Reset mid-stall (countdown 1) with dmem_busy = 1 -> next cycle all enables 1, flushes 0, counters 0, fwd_sel 0.
- add x5 followed by sub x6,x5,x7 -> fwd_sel_a = 1 while sub is in EX; no stall; stall_cnt stays 0.
- lw x5 followed by add x6,x0,x5 with LU_STALL = 1:
  - exactly one cycle of pc_en = 0 and id_ex_flush = 1;
  - then fwd_sel_b = 2 for the add;
  - stall_cnt = 1.
- Same sequence with LU_STALL = 3 -> three bubbles; fwd_sel_b = 0; stall_cnt = 3.
- Taken branch in EX while a load-use stall is pending:
  - if_id_flush = id_ex_flush = 1, countdown cleared, flush_cnt = 1;
  - the younger instruction never forwards.
- dmem_busy high for 4 cycles with ex_take_branch = 1:
  - all enables 0 for 4 cycles, freeze_cnt = 4;
  - the flush occurs on cycle 5;
  - writing x0 then reading x0 always yields fwd_sel = 0.
